mc_main_ctrl: RTL and testbench

Main control FSM for the multicycle MIPS datapath. Decodes opcode/funct/rt from the IR and sequences fetch, decode, execute, memory and writeback phases. Drives all datapath enables and mux selects, and produces the 4-bit aluop consumed by the ALU-control decoder. Stalls on a memory-ready handshake and halts on illegal opcodes.

---
 rtl/mc_ctrl_pkg.sv | 99 +++++++++
 rtl/mc_aluop_enc.sv | 40 ++++
 rtl/mc_main_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_mc_main_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mc_ctrl_pkg
//  Description : Shared encodings for the multicycle MIPS control path:
//                FSM state codes, opcode/funct/rt constants, ALU-control
//                class codes (aluop) and datapath mux-select encodings.
//                The ALU-control decoder imports the same aluop codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package mc_ctrl_pkg;

   typedef logic [3:0] state_t;

   // FSM state encodings (also visible on state_o)
   localparam state_t ST_FETCH    = 4'd0;
   localparam state_t ST_DECODE   = 4'd1;
   localparam state_t ST_MEM_ADDR = 4'd2;
   localparam state_t ST_MEM_RD   = 4'd3;
   localparam state_t ST_MEM_WB   = 4'd4;
   localparam state_t ST_MEM_WR   = 4'd5;
   localparam state_t ST_R_EXEC   = 4'd6;
   localparam state_t ST_R_WB     = 4'd7;
   localparam state_t ST_BRANCH   = 4'd8;
   localparam state_t ST_JUMP     = 4'd9;
   localparam state_t ST_I_EXEC   = 4'd10;
   localparam state_t ST_I_WB     = 4'd11;
   localparam state_t ST_JR       = 4'd12;
   localparam state_t ST_HALT     = 4'd15;

   // Opcodes
   localparam logic [5:0] OP_RTYPE  = 6'h00;
   localparam logic [5:0] OP_REGIMM = 6'h01;
   localparam logic [5:0] OP_J      = 6'h02;
   localparam logic [5:0] OP_JAL    = 6'h03;
   localparam logic [5:0] OP_BEQ    = 6'h04;
   localparam logic [5:0] OP_BNE    = 6'h05;
   localparam logic [5:0] OP_BLEZ   = 6'h06;
   localparam logic [5:0] OP_BGTZ   = 6'h07;
   localparam logic [5:0] OP_ADDI   = 6'h08;
   localparam logic [5:0] OP_ADDIU  = 6'h09;
   localparam logic [5:0] OP_SLTI   = 6'h0a;
   localparam logic [5:0] OP_SLTIU  = 6'h0b;
   localparam logic [5:0] OP_ANDI   = 6'h0c;
   localparam logic [5:0] OP_ORI    = 6'h0d;
   localparam logic [5:0] OP_XORI   = 6'h0e;
   localparam logic [5:0] OP_LUI    = 6'h0f;
   localparam logic [5:0] OP_LW     = 6'h23;
   localparam logic [5:0] OP_SW     = 6'h2b;

   // funct / rt selectors
   localparam logic [5:0] FN_JR     = 6'h08;
   localparam logic [5:0] FN_JALR   = 6'h09;
   localparam logic [4:0] RT_BLTZ   = 5'd0;
   localparam logic [4:0] RT_BGEZ   = 5'd1;

   // ALU-control class codes
   localparam logic [3:0] ALUOP_ADD   = 4'h0;
   localparam logic [3:0] ALUOP_SUB   = 4'h1;  // beq
   localparam logic [3:0] ALUOP_RTYPE = 4'h2;
   localparam logic [3:0] ALUOP_ADDI  = 4'h3;
   localparam logic [3:0] ALUOP_ADDIU = 4'h4;
   localparam logic [3:0] ALUOP_AND   = 4'h5;
   localparam logic [3:0] ALUOP_OR    = 4'h6;
   localparam logic [3:0] ALUOP_XOR   = 4'h7;
   localparam logic [3:0] ALUOP_LUI   = 4'h8;
   localparam logic [3:0] ALUOP_SLT   = 4'h9;
   localparam logic [3:0] ALUOP_SLTU  = 4'ha;
   localparam logic [3:0] ALUOP_BNE   = 4'hb;
   localparam logic [3:0] ALUOP_BGTZ  = 4'hc;
   localparam logic [3:0] ALUOP_BLEZ  = 4'hd;
   localparam logic [3:0] ALUOP_BLTZ  = 4'he;
   localparam logic [3:0] ALUOP_BGEZ  = 4'hf;

   // Mux-select encodings
   localparam logic [1:0] REGDST_RT   = 2'd0;
   localparam logic [1:0] REGDST_RD   = 2'd1;
   localparam logic [1:0] REGDST_RA   = 2'd2;
   localparam logic [1:0] M2R_ALUOUT  = 2'd0;
   localparam logic [1:0] M2R_MDR     = 2'd1;
   localparam logic [1:0] M2R_PC      = 2'd2;
   localparam logic       SRCA_PC     = 1'b0;
   localparam logic       SRCA_A      = 1'b1;
   localparam logic [1:0] SRCB_B      = 2'd0;
   localparam logic [1:0] SRCB_FOUR   = 2'd1;
   localparam logic [1:0] SRCB_IMM    = 2'd2;
   localparam logic [1:0] SRCB_IMMSH2 = 2'd3;
   localparam logic [1:0] PCSRC_ALU   = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT= 2'd1;
   localparam logic [1:0] PCSRC_JUMP  = 2'd2;
   localparam logic [1:0] PCSRC_REG   = 2'd3;

   // REGIMM is only a branch for bltz/bgez; other rt values are illegal.
   function automatic logic is_branch(input logic [5:0] op, input logic [4:0] rt_f);
      return (op inside {OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ}) ||
             (op == OP_REGIMM && (rt_f == RT_BLTZ || rt_f == RT_BGEZ));
   endfunction

endpackage
`default_nettype wire

// File: rtl/mc_aluop_enc.sv
`default_nettype none
// ============================================================================
//  Module      : mc_aluop_enc
//  Description : Combinational opcode/rt -> aluop class encoder used in the
//                I_EXEC and BRANCH states.
//  Ports       : opcode (6)  IR[31:26]
//                rt     (5)  IR[20:16], splits REGIMM into bltz/bgez
//                aluop  (4)  ALU-control class code, 0 when not applicable
//  Revision    : 1.0 - initial release
// ============================================================================
module mc_aluop_enc
   import mc_ctrl_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [4:0] rt,
   output logic [3:0] aluop
);

   always_comb begin
      aluop = ALUOP_ADD;
      unique case (opcode)
         OP_BEQ:    aluop = ALUOP_SUB;
         OP_BNE:    aluop = ALUOP_BNE;
         OP_BLEZ:   aluop = ALUOP_BLEZ;
         OP_BGTZ:   aluop = ALUOP_BGTZ;
         OP_REGIMM: aluop = (rt == RT_BGEZ) ? ALUOP_BGEZ : ALUOP_BLTZ;
         OP_ADDI:   aluop = ALUOP_ADDI;
         OP_ADDIU:  aluop = ALUOP_ADDIU;
         OP_SLTI:   aluop = ALUOP_SLT;
         OP_SLTIU:  aluop = ALUOP_SLTU;
         OP_ANDI:   aluop = ALUOP_AND;
         OP_ORI:    aluop = ALUOP_OR;
         OP_XORI:   aluop = ALUOP_XOR;
         OP_LUI:    aluop = ALUOP_LUI;
         default:   aluop = ALUOP_ADD;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mc_main_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mc_main_ctrl
//  Description : Main control FSM for the multicycle MIPS datapath. Sequences
//                fetch/decode/execute/memory/writeback, drives all datapath
//                enables and mux selects, stalls on mem_ready and halts
//                (sticky) on illegal opcodes.
//  Ports       : clk, rst_n (sync, active low)
//                opcode/funct/rt  IR fields
//                mem_ready        memory handshake
//                pc_write, pc_write_cond, iord, mem_read, mem_write,
//                ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
//                alu_src_b, aluop, pc_source   datapath controls
//                halted, state_o, retired       status/debug
//  Revision    : 1.0 - initial release
// ============================================================================
module mc_main_ctrl
   import mc_ctrl_pkg::*;
#(
   parameter int RETIRE_W = 32
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [5:0]          opcode,
   input  logic [5:0]          funct,
   input  logic [4:0]          rt,
   input  logic                mem_ready,
   output logic                pc_write,
   output logic                pc_write_cond,
   output logic                iord,
   output logic                mem_read,
   output logic                mem_write,
   output logic                ir_write,
   output logic [1:0]          reg_dst,
   output logic [1:0]          mem_to_reg,
   output logic                reg_write,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic [3:0]          aluop,
   output logic [1:0]          pc_source,
   output logic                halted,
   output logic [3:0]          state_o,
   output logic [RETIRE_W-1:0] retired
);

   state_t                state_q, state_d;
   logic                  halted_q;
   logic [RETIRE_W-1:0]   retired_q;
   logic                  retire;
   logic [3:0]            enc_aluop;

   // Ungated write/request strobes; gated by rst_n at the ports
   logic pc_write_s, pc_write_cond_s, mem_read_s, mem_write_s, ir_write_s, reg_write_s;

   mc_aluop_enc u_aluop_enc (
      .opcode (opcode),
      .rt     (rt),
      .aluop  (enc_aluop)
   );

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_FETCH;
         halted_q  <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_d == ST_HALT)
            halted_q <= 1'b1;
         if (retire)
            retired_q <= retired_q + {{(RETIRE_W-1){1'b0}}, 1'b1};
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      retire  = 1'b0;
      case (state_q)
         ST_FETCH:    if (mem_ready) state_d = ST_DECODE;
         ST_DECODE: begin
            if (opcode == OP_RTYPE)
               state_d = (funct == FN_JR || funct == FN_JALR) ? ST_JR : ST_R_EXEC;
            else if (opcode == OP_LW || opcode == OP_SW)
               state_d = ST_MEM_ADDR;
            else if (is_branch(opcode, rt))
               state_d = ST_BRANCH;
            else if (opcode == OP_J || opcode == OP_JAL)
               state_d = ST_JUMP;
            else if (opcode >= OP_ADDI && opcode <= OP_LUI)
               state_d = ST_I_EXEC;
            else
               state_d = ST_HALT;
         end
         ST_MEM_ADDR: state_d = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
         ST_MEM_RD:   if (mem_ready) state_d = ST_MEM_WB;
         ST_MEM_WR: begin
            if (mem_ready) begin
               state_d = ST_FETCH;
               retire  = 1'b1;
            end
         end
         ST_R_EXEC:   state_d = ST_R_WB;
         ST_I_EXEC:   state_d = ST_I_WB;
         ST_MEM_WB, ST_R_WB, ST_I_WB, ST_BRANCH, ST_JUMP, ST_JR: begin
            state_d = ST_FETCH;
            retire  = 1'b1;
         end
         ST_HALT:     state_d = ST_HALT;
         default:     state_d = ST_HALT;  // unused codes are treated as illegal
      endcase
   end

   // ---------------------------------------------------------------- outputs
   always_comb begin
      pc_write_s      = 1'b0;
      pc_write_cond_s = 1'b0;
      mem_read_s      = 1'b0;
      mem_write_s     = 1'b0;
      ir_write_s      = 1'b0;
      reg_write_s     = 1'b0;
      iord            = 1'b0;
      reg_dst         = REGDST_RT;
      mem_to_reg      = M2R_ALUOUT;
      alu_src_a       = SRCA_PC;
      alu_src_b       = SRCB_B;
      aluop           = ALUOP_ADD;
      pc_source       = PCSRC_ALU;
      case (state_q)
         ST_FETCH: begin
            mem_read_s = 1'b1;
            alu_src_b  = SRCB_FOUR;
            // IR and PC+4 commit only when the instruction word is valid
            ir_write_s = mem_ready;
            pc_write_s = mem_ready;
         end
         ST_DECODE:   alu_src_b = SRCB_IMMSH2;  // branch target precompute
         ST_MEM_ADDR: begin
            alu_src_a = SRCA_A;
            alu_src_b = SRCB_IMM;
         end
         ST_MEM_RD: begin
            mem_read_s = 1'b1;
            iord       = 1'b1;
         end
         ST_MEM_WB: begin
            reg_write_s = 1'b1;
            mem_to_reg  = M2R_MDR;
         end
         ST_MEM_WR: begin
            mem_write_s = 1'b1;
            iord        = 1'b1;
         end
         ST_R_EXEC: begin
            alu_src_a = SRCA_A;
            aluop     = ALUOP_RTYPE;
         end
         ST_R_WB: begin
            reg_write_s = 1'b1;
            reg_dst     = REGDST_RD;
         end
         ST_I_EXEC: begin
            alu_src_a = SRCA_A;
            alu_src_b = SRCB_IMM;
            aluop     = enc_aluop;
         end
         ST_I_WB:     reg_write_s = 1'b1;
         ST_BRANCH: begin
            alu_src_a       = SRCA_A;
            pc_write_cond_s = 1'b1;
            pc_source       = PCSRC_ALUOUT;
            aluop           = enc_aluop;
         end
         ST_JUMP: begin
            pc_write_s = 1'b1;
            pc_source  = PCSRC_JUMP;
            if (opcode == OP_JAL) begin
               reg_write_s = 1'b1;
               reg_dst     = REGDST_RA;
               mem_to_reg  = M2R_PC;
            end
         end
         ST_JR: begin
            pc_write_s = 1'b1;
            pc_source  = PCSRC_REG;
            if (funct == FN_JALR) begin
               reg_write_s = 1'b1;
               reg_dst     = REGDST_RD;
               mem_to_reg  = M2R_PC;
            end
         end
         default: ;
      endcase
   end

   // Reset low suppresses every side effect, even mid-instruction
   assign pc_write      = pc_write_s      & rst_n;
   assign pc_write_cond = pc_write_cond_s & rst_n;
   assign mem_read      = mem_read_s      & rst_n;
   assign mem_write     = mem_write_s     & rst_n;
   assign ir_write      = ir_write_s      & rst_n;
   assign reg_write     = reg_write_s     & rst_n;

   assign halted  = halted_q;
   assign state_o = state_q;
   assign retired = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_main_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mc_main_ctrl
//  Description : Directed self-checking bench for mc_main_ctrl. Uses a
//                4-bit retired counter so the wrap-around is reachable.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_main_ctrl;

   localparam int RW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [5:0]    opcode, funct;
   logic [4:0]    rt;
   logic          mem_ready;
   logic          pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
   logic [1:0]    reg_dst, mem_to_reg, alu_src_b, pc_source;
   logic          reg_write, alu_src_a, halted;
   logic [3:0]    aluop, state_o;
   logic [RW-1:0] retired;

   int tests = 0;
   int fails = 0;

   mc_main_ctrl #(.RETIRE_W(RW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .opcode        (opcode),
      .funct         (funct),
      .rt            (rt),
      .mem_ready     (mem_ready),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .iord          (iord),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .ir_write      (ir_write),
      .reg_dst       (reg_dst),
      .mem_to_reg    (mem_to_reg),
      .reg_write     (reg_write),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .aluop         (aluop),
      .pc_source     (pc_source),
      .halted        (halted),
      .state_o       (state_o),
      .retired       (retired)
   );

   always #5 clk = ~clk;

   // write/request strobes: pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write
   logic [5:0] strobes;
   assign strobes = {pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write};

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   int lw_seq[5]   = '{0, 1, 2, 3, 4};
   int r_seq[4]    = '{0, 1, 6, 7};
   logic [5:0] i_ops[10]  = '{6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h08, 6'h08};
   logic [3:0] i_alu[10]  = '{4'h3, 4'h4, 4'h9, 4'ha, 4'h5, 4'h6, 4'h7, 4'h8, 4'h3, 4'h3};

   initial begin
      rst_n = 1'b0; opcode = 6'h23; funct = 6'h00; rt = 5'd0; mem_ready = 1'b1;
      repeat (2) step();
      rst_n = 1'b1;
      #1;
      chk("reset_state", 32'(state_o), 32'd0);
      chk("reset_retired", 32'(retired), 32'd0);
      chk("reset_halted", 32'(halted), 32'd0);

      // ---- lw interrupted by reset while stalled in MEM_RD
      chk("fetch_strobes", 32'(strobes), 32'b101010);
      step();
      chk("decode_state", 32'(state_o), 32'd1);
      chk("decode_srcb", 32'(alu_src_b), 32'd3);
      step();
      mem_ready = 1'b0;
      step();
      chk("memrd_read", 32'({mem_read, iord}), 32'b11);
      step();
      chk("memrd_stall", 32'(state_o), 32'd3);
      rst_n = 1'b0;
      #1;
      chk("rst_strobes_now", 32'(strobes), 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_state", 32'(state_o), 32'd0);
         chk("rst_strobes", 32'(strobes), 32'd0);
      end
      rst_n = 1'b1; mem_ready = 1'b1;
      #1;
      chk("rst_retired", 32'(retired), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);

      // ---- lw, no stalls: 5 cycles
      for (int i = 0; i < 5; i++) begin
         chk("lw_state", 32'(state_o), 32'(lw_seq[i]));
         chk("lw_regwr", 32'(reg_write), (i == 4) ? 32'd1 : 32'd0);
         if (i == 4) chk("lw_m2r", 32'(mem_to_reg), 32'd1);
         step();
      end
      chk("lw_done", 32'(state_o), 32'd0);
      chk("lw_retired", 32'(retired), 32'd1);

      // ---- sw with 3 stall cycles in MEM_WR: 7 cycles total
      opcode = 6'h2b;
      repeat (3) step();
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("sw_wait_state", 32'(state_o), 32'd5);
         chk("sw_wait_wr", 32'({mem_write, iord, reg_write}), 32'b110);
         step();
      end
      mem_ready = 1'b1;
      chk("sw_ready_wr", 32'({state_o, mem_write}), {27'd0, 4'd5, 1'b1});
      step();
      chk("sw_done", 32'(state_o), 32'd0);
      chk("sw_retired", 32'(retired), 32'd2);

      // ---- bgez / bltz
      opcode = 6'h01; rt = 5'd1;
      repeat (2) step();
      chk("bgez_state", 32'(state_o), 32'd8);
      chk("bgez_aluop", 32'(aluop), 32'hf);
      chk("bgez_ctrl", 32'({pc_write_cond, pc_source, pc_write, alu_src_a}), 32'b10101);
      rt = 5'd0;
      #1;
      chk("bltz_aluop", 32'(aluop), 32'he);
      step();
      chk("br_retired", 32'({state_o, retired}), {24'd0, 4'd0, 4'd3});

      // ---- jal
      opcode = 6'h03;
      repeat (2) step();
      chk("jal_state", 32'(state_o), 32'd9);
      chk("jal_ctrl", 32'({pc_write, reg_write, reg_dst, mem_to_reg, pc_source}), 32'b11_10_10_10);
      step();
      chk("jal_retired", 32'(retired), 32'd4);

      // ---- jr
      opcode = 6'h00; funct = 6'h08;
      repeat (2) step();
      chk("jr_state", 32'(state_o), 32'd12);
      chk("jr_ctrl", 32'({pc_write, reg_write, pc_source}), 32'b1011);
      step();
      chk("jr_retired", 32'(retired), 32'd5);

      // ---- R-type add
      funct = 6'h20;
      for (int i = 0; i < 4; i++) begin
         chk("r_state", 32'(state_o), 32'(r_seq[i]));
         if (i == 2) chk("r_aluop", 32'({aluop, alu_src_a, alu_src_b}), 32'b0010_1_00);
         if (i == 3) chk("r_wb", 32'({reg_write, reg_dst, mem_to_reg}), 32'b1_01_00);
         step();
      end
      chk("r_retired", 32'(retired), 32'd6);

      // ---- I-type sweep; 10 more retirements wrap the 4-bit counter to 0
      for (int k = 0; k < 10; k++) begin
         opcode = i_ops[k];
         repeat (2) step();
         chk("i_state", 32'(state_o), 32'd10);
         chk("i_aluop", 32'(aluop), 32'(i_alu[k]));
         step();
         chk("i_wb", 32'({state_o, reg_write, reg_dst}), {25'd0, 4'd11, 1'b1, 2'd0});
         step();
         if (k == 8) chk("pre_wrap", 32'(retired), 32'hf);
      end
      chk("wrap_retired", 32'(retired), 32'd0);

      // ---- illegal opcode -> sticky HALT
      opcode = 6'h3f;
      repeat (2) step();
      chk("halt_state", 32'(state_o), 32'd15);
      chk("halt_flag", 32'(halted), 32'd1);
      for (int i = 0; i < 20; i++) begin
         step();
         chk("halt_sticky", 32'({state_o, halted, strobes}), {21'd0, 4'd15, 1'b1, 6'd0});
      end
      chk("halt_retired", 32'(retired), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
